// File: rtl/boss_pkg.sv
// Shared types and aim constants for the boss attack scheduler.
// Also holds the pattern rotation and the distance-to-step mapping.
package boss_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        SPREAD = 2'd1,
        BURST  = 2'd2
    } pattern_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COOLDOWN = 3'd1,
        PICK     = 3'd2,
        LAUNCH   = 3'd3,
        GAP      = 3'd4
    } sched_state_t;

    localparam logic [10:0] AIM_TH_LO  = 11'd32;
    localparam logic [10:0] AIM_TH_MID = 11'd128;
    localparam logic [10:0] AIM_TH_HI  = 11'd256;

    function automatic pattern_t next_pattern(input pattern_t p);
        case (p)
            SINGLE:  return SPREAD;
            SPREAD:  return BURST;
            default: return SINGLE;
        endcase
    endfunction

    // Coarse speed bands: the farther the player, the steeper the shot.
    function automatic logic [2:0] aim_step(input logic [10:0] dx);
        if (dx >= AIM_TH_HI)       return 3'd3;
        else if (dx >= AIM_TH_MID) return 3'd2;
        else if (dx >= AIM_TH_LO)  return 3'd1;
        else                       return 3'd0;
    endfunction

endpackage

// File: rtl/slot_picker.sv
// Lowest-index free projectile slot finder (pure combinational priority encoder).
module slot_picker #(
    parameter int NSLOT = 4
) (
    input  logic [NSLOT-1:0]         i_busy,
    output logic [$clog2(NSLOT)-1:0] o_idx,
    output logic                     o_found
);
    localparam int IW = $clog2(NSLOT);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Scan downwards so the lowest free index wins.
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!i_busy[i]) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/boss_attack_scheduler.sv
// Boss volley sequencer: cooldown, free-slot allocation, per-slot aim config and
// shoot handshake with timeout, rotating SINGLE -> SPREAD -> BURST patterns.
module boss_attack_scheduler
    import boss_pkg::*;
#(
    parameter int NSLOT         = 4,
    parameter int COOLDOWN_FR   = 60,
    parameter int BURST_GAP_FR  = 8,
    parameter int Y_STEP        = 2,
    parameter int LAUNCH_TMO_FR = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               enable,
    input  logic [9:0]         boss_x_pos,
    input  logic [9:0]         boss_y_pos,
    input  logic [9:0]         player_x_pos,
    input  logic [NSLOT-1:0]   slot_busy,
    output logic [NSLOT-1:0]   shoot,
    output logic [NSLOT*3-1:0] x_step,
    output logic [NSLOT*3-1:0] y_step,
    output logic [NSLOT-1:0]   negative_x,
    output logic [1:0]         pattern,
    output logic               volley_done,
    output logic [7:0]         shots_dropped
);
    localparam int IW = $clog2(NSLOT);
    localparam int CW = 8;

    sched_state_t   r_state, w_state_next;
    pattern_t       r_pattern;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [1:0]     r_shots_left;
    logic [IW-1:0]  r_sel, w_pick_idx;
    logic           r_frame_q, r_frame_qq, r_volley_done;
    logic [7:0]     r_dropped;
    logic           w_tick, w_found, w_fire, w_ack, w_tmo, w_shot_end, w_last;
    logic           w_cd_done, w_gap_done, w_tick_used;
    logic [10:0]    w_dx_signed, w_dx;
    logic [2:0]     w_cfg_x;
    logic           w_cfg_neg;
    logic           w_unused_y;

    // boss_y_pos is latched by each projectile itself; nothing here needs it.
    assign w_unused_y = ^boss_y_pos;

    assign w_tick = r_frame_q & ~r_frame_qq;

    slot_picker #(.NSLOT(NSLOT)) u_picker (
        .i_busy  (slot_busy),
        .o_idx   (w_pick_idx),
        .o_found (w_found)
    );

    assign w_cd_done   = enable && r_state == COOLDOWN && w_tick && r_cnt == CW'(COOLDOWN_FR - 1);
    assign w_gap_done  = enable && r_state == GAP && w_tick && r_cnt == CW'(BURST_GAP_FR - 1);
    assign w_fire      = enable && r_state == PICK && w_found;
    assign w_ack       = enable && r_state == LAUNCH && slot_busy[r_sel];
    assign w_tmo       = enable && r_state == LAUNCH && !slot_busy[r_sel] && w_tick
                         && r_cnt == CW'(LAUNCH_TMO_FR - 1);
    assign w_shot_end  = w_ack || w_tmo;
    assign w_last      = w_shot_end && r_shots_left == 2'd1;
    assign w_tick_used = w_cd_done || w_tmo || w_gap_done;

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_state_next = COOLDOWN;
                COOLDOWN: if (w_cd_done) w_state_next = PICK;
                PICK:     if (w_found) w_state_next = LAUNCH;
                LAUNCH: begin
                    if (w_shot_end) begin
                        if (r_shots_left == 2'd1)    w_state_next = COOLDOWN;
                        else if (r_pattern == BURST) w_state_next = GAP;
                        else                         w_state_next = PICK;
                    end
                end
                GAP:      if (w_gap_done) w_state_next = PICK;
                default:  w_state_next = IDLE;
            endcase
        end
    end

    // A tick that did not trigger the transition itself is credited to the state being entered.
    always_comb begin
        w_cnt_next  = r_cnt;
        w_dx_signed = {1'b0, player_x_pos} - {1'b0, boss_x_pos};
        w_dx        = w_dx_signed[10] ? (~w_dx_signed + 11'd1) : w_dx_signed;
        w_cfg_x     = aim_step(w_dx);
        w_cfg_neg   = (player_x_pos < boss_x_pos);
        if (!enable)
            w_cnt_next = '0;
        else if (w_state_next != r_state)
            w_cnt_next = (w_tick && !w_tick_used) ? CW'(1) : '0;
        else if (w_tick && (r_state == COOLDOWN || r_state == LAUNCH || r_state == GAP))
            w_cnt_next = r_cnt + CW'(1);
        if (r_pattern == SPREAD) begin
            case (r_shots_left)
                2'd3:    begin w_cfg_x = 3'd2; w_cfg_neg = 1'b1; end
                2'd2:    begin w_cfg_x = 3'd0; w_cfg_neg = 1'b0; end
                default: begin w_cfg_x = 3'd2; w_cfg_neg = 1'b0; end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_frame_q     <= 1'b0;
            r_frame_qq    <= 1'b0;
            r_cnt         <= '0;
            r_shots_left  <= '0;
            r_sel         <= '0;
            r_pattern     <= SINGLE;
            r_volley_done <= 1'b0;
            r_dropped     <= '0;
        end else begin
            r_frame_q     <= frame_clk;
            r_frame_qq    <= r_frame_q;
            r_cnt         <= w_cnt_next;
            r_volley_done <= w_last;
            if (!enable)         r_shots_left <= '0;
            else if (w_cd_done)  r_shots_left <= (r_pattern == SINGLE) ? 2'd1 : 2'd3;
            else if (w_shot_end) r_shots_left <= r_shots_left - 2'd1;
            if (w_last) r_pattern <= next_pattern(r_pattern);
            if (w_fire) r_sel <= w_pick_idx;
            if (w_tmo && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
        end
    end

    // Per-slot config only changes when that slot is picked, so in-flight shots keep theirs.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic       r_shoot_s, r_neg_s;
            logic [2:0] r_x_s, r_y_s;
            logic       w_hit, w_mine;
            assign w_hit  = w_fire && (w_pick_idx == IW'(gi));
            assign w_mine = (r_sel == IW'(gi));
            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    r_shoot_s <= 1'b0;
                    r_neg_s   <= 1'b0;
                    r_x_s     <= '0;
                    r_y_s     <= '0;
                end else begin
                    if (!enable || (w_shot_end && w_mine)) r_shoot_s <= 1'b0;
                    else if (w_hit)                        r_shoot_s <= 1'b1;
                    if (w_hit) begin
                        r_x_s   <= w_cfg_x;
                        r_neg_s <= w_cfg_neg;
                        r_y_s   <= 3'(Y_STEP);
                    end
                end
            end
            assign shoot[gi]            = r_shoot_s;
            assign negative_x[gi]       = r_neg_s;
            assign x_step[3*gi +: 3]    = r_x_s;
            assign y_step[3*gi +: 3]    = r_y_s;
        end
    endgenerate

    assign pattern       = r_pattern;
    assign volley_done   = r_volley_done;
    assign shots_dropped = r_dropped;

endmodule

// File: tb/tb_boss_attack_scheduler.sv
// Directed bench for boss_attack_scheduler: one task per scenario, inline checks,
// a small busy-echo model standing in for the projectile bank.
module tb_boss_attack_scheduler;
    localparam int NSLOT = 4;

    logic             clk = 1'b0;
    logic             Reset_n, frame_clk, enable;
    logic [9:0]       boss_x, boss_y, player_x;
    logic [NSLOT-1:0] slot_busy;
    logic [NSLOT-1:0] shoot, negative_x;
    logic [NSLOT*3-1:0] x_step, y_step;
    logic [1:0]       pattern;
    logic             volley_done;
    logic [7:0]       shots_dropped;

    int tests = 0, fails = 0, frame_edges = 0, onehot_err = 0;
    logic [NSLOT-1:0] echo_busy, hold_mask;
    int  echo_cnt [NSLOT];
    bit  echo_en;

    boss_attack_scheduler #(.NSLOT(NSLOT)) dut (
        .Clk(clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .enable(enable),
        .boss_x_pos(boss_x), .boss_y_pos(boss_y), .player_x_pos(player_x),
        .slot_busy(slot_busy), .shoot(shoot), .x_step(x_step), .y_step(y_step),
        .negative_x(negative_x), .pattern(pattern), .volley_done(volley_done),
        .shots_dropped(shots_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        frame_clk = 1'b0;
        #3;
        forever begin
            #80 frame_clk = 1'b1; frame_edges++;
            #80 frame_clk = 1'b0;
        end
    end

    function automatic logic [2:0] xs(input int i); return x_step[3*i +: 3]; endfunction
    function automatic logic [2:0] ys(input int i); return y_step[3*i +: 3]; endfunction

    // Advance one clock, sample 1ns after the edge and run the busy-echo model.
    task automatic step();
        @(posedge clk); #1;
        if ($countones(shoot) > 1) onehot_err++;
        for (int i = 0; i < NSLOT; i++) begin
            if (echo_en && shoot[i] && !echo_busy[i]) begin
                echo_cnt[i]++;
                if (echo_cnt[i] >= 3) echo_busy[i] = 1'b1;
            end
        end
        slot_busy = echo_busy | hold_mask;
    endtask

    task automatic clear_busy();
        echo_busy = '0;
        for (int i = 0; i < NSLOT; i++) echo_cnt[i] = 0;
        slot_busy = hold_mask;
    endtask

    task automatic wait_shoot(input int budget, output bit ok);
        int n = 0;
        while (shoot != 0 && n < budget) begin step(); n++; end
        while (shoot == 0 && n < budget) begin step(); n++; end
        ok = (shoot != 0);
        if (ok) $display("[TB] shot shoot=%b x=%0d,%0d,%0d,%0d neg=%b pat=%0d edges=%0d",
                         shoot, xs(0), xs(1), xs(2), xs(3), negative_x, pattern, frame_edges);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!volley_done && n < budget) begin step(); n++; end
        ok = volley_done;
        if (ok) $display("[TB] volley_done pattern=%0d dropped=%0d", pattern, shots_dropped);
    endtask

    task automatic align_enable(output int e0);
        int e;
        e = frame_edges;
        while (frame_edges == e) step();
        repeat (4) step();
        enable = 1'b1;
        e0 = frame_edges;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; enable = 1'b1;
        repeat (3) step();
        tests++; if (shoot !== 4'b0) begin fails++; $display("FAIL reset_shoot: got %b want 0000", shoot); end
        tests++; if (x_step !== '0) begin fails++; $display("FAIL reset_x_step: got %h want 0", x_step); end
        tests++; if (y_step !== '0) begin fails++; $display("FAIL reset_y_step: got %h want 0", y_step); end
        tests++; if (negative_x !== 4'b0) begin fails++; $display("FAIL reset_neg: got %b want 0000", negative_x); end
        tests++; if (pattern !== 2'd0) begin fails++; $display("FAIL reset_pattern: got %0d want 0", pattern); end
        tests++; if (volley_done !== 1'b0) begin fails++; $display("FAIL reset_volley_done: got %b want 0", volley_done); end
        tests++; if (shots_dropped !== 8'd0) begin fails++; $display("FAIL reset_dropped: got %0d want 0", shots_dropped); end
        enable = 1'b0;
        Reset_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_single();
        int e0; bit ok;
        boss_x = 10'd320; player_x = 10'd100; echo_en = 1'b1; hold_mask = '0; clear_busy();
        align_enable(e0);
        wait_shoot(1200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_shoot_timeout: got none want shoot"); end
        tests++; if (frame_edges - e0 != 60) begin fails++; $display("FAIL single_cooldown: got %0d ticks want 60", frame_edges - e0); end
        tests++; if (shoot !== 4'b0001) begin fails++; $display("FAIL single_slot: got %b want 0001", shoot); end
        tests++; if (xs(0) !== 3'd2) begin fails++; $display("FAIL single_x_step: got %0d want 2", xs(0)); end
        tests++; if (negative_x[0] !== 1'b1) begin fails++; $display("FAIL single_neg: got %b want 1", negative_x[0]); end
        tests++; if (ys(0) !== 3'd2) begin fails++; $display("FAIL single_y_step: got %0d want 2", ys(0)); end
        wait_done(40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_volley_done: got 0 want 1"); end
        tests++; if (pattern !== 2'd1) begin fails++; $display("FAIL single_pattern: got %0d want 1", pattern); end
        step();
        tests++; if (volley_done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %b want 0", volley_done); end
    endtask

    task automatic test_spread();
        bit ok; int stray = 0;
        hold_mask = 4'b0011; clear_busy();
        wait_shoot(1200, ok);
        tests++; if (!ok || shoot !== 4'b0100) begin fails++; $display("FAIL spread_shot1_slot: got %b want 0100", shoot); end
        tests++; if (xs(2) !== 3'd2 || negative_x[2] !== 1'b1) begin fails++; $display("FAIL spread_shot1_cfg: got x=%0d neg=%b want x=2 neg=1", xs(2), negative_x[2]); end
        wait_shoot(40, ok);
        tests++; if (!ok || shoot !== 4'b1000) begin fails++; $display("FAIL spread_shot2_slot: got %b want 1000", shoot); end
        tests++; if (xs(3) !== 3'd0 || negative_x[3] !== 1'b0) begin fails++; $display("FAIL spread_shot2_cfg: got x=%0d neg=%b want x=0 neg=0", xs(3), negative_x[3]); end
        for (int n = 0; n < 40 && shoot != 0; n++) step();
        for (int n = 0; n < 60; n++) begin step(); if (shoot != 0 || volley_done) stray++; end
        tests++; if (stray != 0) begin fails++; $display("FAIL spread_stall: got %0d active cycles want 0", stray); end
        tests++; if (xs(0) !== 3'd2 || negative_x[0] !== 1'b1) begin fails++; $display("FAIL spread_cfg_kept: got x=%0d neg=%b want x=2 neg=1", xs(0), negative_x[0]); end
        hold_mask = 4'b0010;
        wait_shoot(40, ok);
        tests++; if (!ok || shoot !== 4'b0001) begin fails++; $display("FAIL spread_shot3_slot: got %b want 0001", shoot); end
        tests++; if (xs(0) !== 3'd2 || negative_x[0] !== 1'b0) begin fails++; $display("FAIL spread_shot3_cfg: got x=%0d neg=%b want x=2 neg=0", xs(0), negative_x[0]); end
        wait_done(40, ok);
        tests++; if (!ok || pattern !== 2'd2) begin fails++; $display("FAIL spread_done: got done=%b pattern=%0d want 1 2", ok, pattern); end
    endtask

    task automatic test_burst();
        bit ok; int prev = 0;
        logic [NSLOT-1:0] want;
        boss_x = 10'd320; player_x = 10'd320; hold_mask = '0; clear_busy();
        for (int k = 0; k < 3; k++) begin
            wait_shoot((k == 0) ? 1200 : 400, ok);
            want = NSLOT'(1) << k;
            tests++; if (!ok || shoot !== want) begin fails++; $display("FAIL burst_slot%0d: got %b want %b", k, shoot, want); end
            tests++; if (xs(k) !== 3'd0 || negative_x[k] !== 1'b0) begin fails++; $display("FAIL burst_cfg%0d: got x=%0d neg=%b want x=0 neg=0", k, xs(k), negative_x[k]); end
            if (k > 0) begin
                tests++; if (frame_edges - prev != 8) begin fails++; $display("FAIL burst_gap%0d: got %0d ticks want 8", k, frame_edges - prev); end
            end
            prev = frame_edges;
        end
        wait_done(40, ok);
        tests++; if (!ok || pattern !== 2'd0) begin fails++; $display("FAIL burst_done: got done=%b pattern=%0d want 1 0", ok, pattern); end
    endtask

    task automatic test_timeout();
        bit ok; int e_rise; int n = 0;
        echo_en = 1'b0; hold_mask = '0; clear_busy();
        boss_x = 10'd320; player_x = 10'd500;
        wait_shoot(1200, ok);
        tests++; if (!ok || shoot !== 4'b0001) begin fails++; $display("FAIL tmo_slot: got %b want 0001", shoot); end
        tests++; if (xs(0) !== 3'd2 || negative_x[0] !== 1'b0) begin fails++; $display("FAIL tmo_cfg: got x=%0d neg=%b want x=2 neg=0", xs(0), negative_x[0]); end
        e_rise = frame_edges;
        while (shoot != 0 && n < 100) begin step(); n++; end
        tests++; if (shoot !== 4'b0) begin fails++; $display("FAIL tmo_drop: got %b want 0000", shoot); end
        tests++; if (frame_edges - e_rise != 2) begin fails++; $display("FAIL tmo_ticks: got %0d want 2", frame_edges - e_rise); end
        wait_done(10, ok);
        tests++; if (!ok || pattern !== 2'd1) begin fails++; $display("FAIL tmo_done: got done=%b pattern=%0d want 1 1", ok, pattern); end
        tests++; if (shots_dropped !== 8'd1) begin fails++; $display("FAIL tmo_dropped: got %0d want 1", shots_dropped); end
        tests++; if (onehot_err != 0) begin fails++; $display("FAIL onehot: got %0d violations want 0", onehot_err); end
    endtask

    task automatic test_enable_drop();
        bit ok; int e0;
        echo_en = 1'b0; hold_mask = '0; clear_busy();
        wait_shoot(1200, ok);
        repeat (3) step();
        tests++; if (!ok || shoot !== 4'b0001) begin fails++; $display("FAIL drop_held: got %b want 0001", shoot); end
        enable = 1'b0;
        step();
        tests++; if (shoot !== 4'b0) begin fails++; $display("FAIL drop_shoot_clear: got %b want 0000", shoot); end
        tests++; if (pattern !== 2'd1 || shots_dropped !== 8'd1) begin fails++; $display("FAIL drop_kept: got pattern=%0d dropped=%0d want 1 1", pattern, shots_dropped); end
        tests++; if (xs(0) !== 3'd2 || negative_x[0] !== 1'b1) begin fails++; $display("FAIL drop_cfg: got x=%0d neg=%b want x=2 neg=1", xs(0), negative_x[0]); end
        repeat (5) step();
        echo_en = 1'b1; clear_busy();
        align_enable(e0);
        wait_shoot(1200, ok);
        tests++; if (!ok || frame_edges - e0 != 60) begin fails++; $display("FAIL drop_restart: got %0d ticks want 60", frame_edges - e0); end
        tests++; if (shoot !== 4'b0001) begin fails++; $display("FAIL drop_restart_slot: got %b want 0001", shoot); end
    endtask

    initial begin
        Reset_n = 1'b0; enable = 1'b0; boss_x = '0; boss_y = 10'd40; player_x = '0;
        hold_mask = '0; echo_en = 1'b0; clear_busy();
        test_reset();
        test_single();
        test_spread();
        test_burst();
        test_timeout();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
